// File: rtl/rgmii_pkg.sv
// rgmii_pkg: speed encodings, nibble-pairing FSM states and the GMII byte record
// shared by the RGMII receive decoder and its nibble packer.
// Pure declarations; no logic, no latency, no backpressure.
package rgmii_pkg;

   localparam int RGMII_NIB_W = 4;

   localparam logic [1:0] SPD_10   = 2'd0;
   localparam logic [1:0] SPD_100  = 2'd1;
   localparam logic [1:0] SPD_1000 = 2'd2;

   typedef enum logic [1:0] {
      NIB_IDLE = 2'd0,
      NIB_LOW  = 2'd1,
      NIB_HIGH = 2'd2
   } nib_state_t;

   typedef struct packed {
      logic [2*RGMII_NIB_W-1:0] rxd;
      logic                     dv;
      logic                     er;
      logic                     vld;
   } gmii_byte_t;

   // 10M and 100M carry one nibble per clock; anything else (incl. reserved 3) is DDR byte mode
   function automatic logic is_sdr(input logic [1:0] spd);
      return (spd == SPD_10) || (spd == SPD_100);
   endfunction

endpackage

// File: rtl/rgmii_nibble_pack.sv
// rgmii_nibble_pack: pairs 10/100M SDR nibbles (low first) into bytes, flags odd nibble counts.
// Latency: byte is presented combinationally in the cycle its high nibble arrives.
// Backpressure: none; the receive stream cannot be stalled.
module rgmii_nibble_pack
   import rgmii_pkg::*;
(
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_en,
   input  logic                     i_dv,
   input  logic                     i_er,
   input  logic [RGMII_NIB_W-1:0]   i_nib,
   output logic                     o_vld,
   output logic [2*RGMII_NIB_W-1:0] o_byte,
   output logic                     o_er,
   output logic                     o_odd,
   output logic                     o_idle
);

   nib_state_t               r_state;
   nib_state_t               w_state_nxt;
   logic [RGMII_NIB_W-1:0]   r_low;
   logic                     r_er_low;
   logic                     w_store;

   // state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= NIB_IDLE;
      else          r_state <= w_state_nxt;
   end

   // next-state: a frame opens only while enabled; dv low in any non-idle state ends it
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         NIB_IDLE: if (i_en && i_dv) w_state_nxt = NIB_HIGH;
         NIB_LOW : w_state_nxt = i_dv ? NIB_HIGH : NIB_IDLE;
         NIB_HIGH: w_state_nxt = i_dv ? NIB_LOW  : NIB_IDLE;
         default : w_state_nxt = NIB_IDLE;
      endcase
   end

   assign w_store = i_dv && (((r_state == NIB_IDLE) && i_en) || (r_state == NIB_LOW));

   // hold the low nibble and its error flag until the matching high nibble arrives
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_low    <= '0;
         r_er_low <= 1'b0;
      end else if (w_store) begin
         r_low    <= i_nib;
         r_er_low <= i_er;
      end
   end

   // outputs: a byte leaves only from HIGH; a missing high nibble yields a zero-padded error byte
   always_comb begin
      o_vld  = 1'b0;
      o_byte = '0;
      o_er   = 1'b0;
      o_odd  = 1'b0;
      o_idle = (r_state == NIB_IDLE);
      if (r_state == NIB_HIGH) begin
         o_vld = 1'b1;
         if (i_dv) begin
            o_byte = {i_nib, r_low};
            o_er   = r_er_low | i_er;
         end else begin
            o_byte = {{RGMII_NIB_W{1'b0}}, r_low};
            o_er   = 1'b1;
            o_odd  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rgmii_rx_byte_decode.sv
// rgmii_rx_byte_decode: DDR/SDR RGMII receive samples -> GMII byte stream, frame/error counters.
// Latency: 1 clk from the sample carrying a byte's last nibble to the registered output.
// Backpressure: none; optional in-band link status decode when RGMII_RX_INBAND_STATUS_EN is defined.
module rgmii_rx_byte_decode
   import rgmii_pkg::*;
#(
   parameter int CNT_W = 16
)
(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [4:0]       i_rx_q1,
   input  logic [4:0]       i_rx_q2,
   input  logic [1:0]       i_speed,
   output logic [7:0]       o_gmii_rxd,
   output logic             o_gmii_rx_dv,
   output logic             o_gmii_rx_er,
   output logic             o_gmii_valid,
   output logic [CNT_W-1:0] o_frame_cnt,
   output logic [CNT_W-1:0] o_err_cnt,
   output logic             o_link_up,
   output logic [1:0]       o_link_speed,
   output logic             o_link_duplex
);

   logic             w_dv;
   logic             w_er;
   logic             w_sdr;
   logic             w_frame_end;
   logic [1:0]       r_speed_lat;
   logic             r_dv_d;
   logic             r_frame_er;
   logic [CNT_W-1:0] r_frame_cnt;
   logic [CNT_W-1:0] r_err_cnt;
   gmii_byte_t       w_out;
   gmii_byte_t       r_out;

   logic                     w_pk_vld;
   logic [2*RGMII_NIB_W-1:0] w_pk_byte;
   logic                     w_pk_er;
   logic                     w_pk_odd;
   logic                     w_pk_idle;

   // RX_CTL carries DV on the rising edge and DV^ER on the falling edge
   assign w_dv        = i_rx_q1[4];
   assign w_er        = i_rx_q1[4] ^ i_rx_q2[4];
   assign w_sdr       = is_sdr(r_speed_lat);
   assign w_frame_end = r_dv_d && !w_dv;

   rgmii_nibble_pack u_nibble_pack (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (w_sdr),
      .i_dv    (w_dv),
      .i_er    (w_er),
      .i_nib   (i_rx_q1[RGMII_NIB_W-1:0]),
      .o_vld   (w_pk_vld),
      .o_byte  (w_pk_byte),
      .o_er    (w_pk_er),
      .o_odd   (w_pk_odd),
      .o_idle  (w_pk_idle)
   );

   // speed only follows the input between frames so a frame is never decoded in two modes
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                 r_speed_lat <= SPD_1000;
      else if (w_pk_idle && !w_dv)  r_speed_lat <= i_speed;
   end

   // select DDR byte or packed nibble pair for the output register
   always_comb begin
      w_out = '0;
      if (!w_sdr) begin
         w_out.rxd = {i_rx_q2[3:0], i_rx_q1[3:0]};
         w_out.dv  = w_dv;
         w_out.er  = w_er;
         w_out.vld = 1'b1;
      end else if (w_pk_vld) begin
         w_out.rxd = w_pk_byte;
         w_out.dv  = 1'b1;
         w_out.er  = w_pk_er;
         w_out.vld = 1'b1;
      end
   end

   // output register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_out <= '0;
      else          r_out <= w_out;
   end

   // per-frame error tracking and wrap-around frame/error counters, bumped on dv falling
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_dv_d      <= 1'b0;
         r_frame_er  <= 1'b0;
         r_frame_cnt <= '0;
         r_err_cnt   <= '0;
      end else begin
         r_dv_d <= w_dv;
         if (w_frame_end) begin
            r_frame_er  <= 1'b0;
            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            if (r_frame_er || w_pk_odd) r_err_cnt <= r_err_cnt + CNT_W'(1);
         end else if (w_dv && w_er) begin
            r_frame_er <= 1'b1;
         end
      end
   end

   assign o_gmii_rxd   = r_out.rxd;
   assign o_gmii_rx_dv = r_out.dv;
   assign o_gmii_rx_er = r_out.er;
   assign o_gmii_valid = r_out.vld;
   assign o_frame_cnt  = r_frame_cnt;
   assign o_err_cnt    = r_err_cnt;

`ifdef RGMII_RX_INBAND_STATUS_EN
   logic [RGMII_NIB_W-1:0] r_st_prev;
   logic                   r_st_have;
   logic                   r_link_up;
   logic [1:0]             r_link_speed;
   logic                   r_link_duplex;
   logic                   w_st_cycle;

   assign w_st_cycle = !w_dv && !w_er;

   // idle status nibble is committed only once it repeats on back-to-back idle cycles
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_st_prev     <= '0;
         r_st_have     <= 1'b0;
         r_link_up     <= 1'b0;
         r_link_speed  <= 2'd0;
         r_link_duplex <= 1'b0;
      end else begin
         r_st_have <= w_st_cycle;
         if (w_st_cycle) begin
            r_st_prev <= i_rx_q1[3:0];
            if (r_st_have && (r_st_prev == i_rx_q1[3:0])) begin
               r_link_up     <= i_rx_q1[0];
               r_link_speed  <= i_rx_q1[2:1];
               r_link_duplex <= i_rx_q1[3];
            end
         end
      end
   end

   assign o_link_up     = r_link_up;
   assign o_link_speed  = r_link_speed;
   assign o_link_duplex = r_link_duplex;
`else
   assign o_link_up     = 1'b0;
   assign o_link_speed  = 2'd0;
   assign o_link_duplex = 1'b0;
`endif

endmodule

// File: tb/tb_rgmii_rx_byte_decode.sv
// tb_rgmii_rx_byte_decode: directed table, corner-case sequences and random traffic
// compared every cycle against a frame/nibble-count level reference model.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_rgmii_rx_byte_decode;

   localparam int CNT_W = 16;

`ifdef RGMII_RX_INBAND_STATUS_EN
   localparam logic       EXP_LU = 1'b1;
   localparam logic [1:0] EXP_LS = 2'd2;
   localparam logic       EXP_LD = 1'b1;
`else
   localparam logic       EXP_LU = 1'b0;
   localparam logic [1:0] EXP_LS = 2'd0;
   localparam logic       EXP_LD = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [4:0]       q1 = 5'h00;
   logic [4:0]       q2 = 5'h00;
   logic [1:0]       spd = 2'd2;
   logic [7:0]       o_rxd;
   logic             o_dv, o_er, o_vld;
   logic [CNT_W-1:0] o_fc, o_ec;
   logic             o_lu;
   logic [1:0]       o_ls;
   logic             o_ld;

   always #5 clk = ~clk;

   rgmii_rx_byte_decode #(.CNT_W(CNT_W)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_rx_q1       (q1),
      .i_rx_q2       (q2),
      .i_speed       (spd),
      .o_gmii_rxd    (o_rxd),
      .o_gmii_rx_dv  (o_dv),
      .o_gmii_rx_er  (o_er),
      .o_gmii_valid  (o_vld),
      .o_frame_cnt   (o_fc),
      .o_err_cnt     (o_ec),
      .o_link_up     (o_lu),
      .o_link_speed  (o_ls),
      .o_link_duplex (o_ld)
   );

   int vectors = 0;
   int miscompares = 0;

   // reference model state: nibble position inside the current frame rather than FSM states
   logic [1:0]  m_spd_lat;
   int          m_nib_idx;
   logic [3:0]  m_low;
   logic        m_low_er;
   logic        m_prev_dv;
   logic        m_frame_bad;
   logic [15:0] m_fcnt, m_ecnt;
   logic        m_lu;
   logic [1:0]  m_ls;
   logic        m_ld;
   logic [7:0]  e_rxd;
   logic        e_dv, e_er, e_vld;
`ifdef RGMII_RX_INBAND_STATUS_EN
   logic [3:0]  m_st_prev;
   logic        m_st_have;
`endif

   function automatic void model_reset();
      m_spd_lat = 2'd2; m_nib_idx = 0; m_low = 4'h0; m_low_er = 1'b0;
      m_prev_dv = 1'b0; m_frame_bad = 1'b0; m_fcnt = 16'd0; m_ecnt = 16'd0;
      m_lu = 1'b0; m_ls = 2'd0; m_ld = 1'b0;
      e_rxd = 8'h00; e_dv = 1'b0; e_er = 1'b0; e_vld = 1'b0;
`ifdef RGMII_RX_INBAND_STATUS_EN
      m_st_prev = 4'h0; m_st_have = 1'b0;
`endif
   endfunction

   // one clock of input; e_* and counters become the values expected after the next edge
   function automatic void model_step(input logic [4:0] a, input logic [4:0] b, input logic [1:0] s);
      logic dv, er, sdr, odd, active;
      dv = a[4]; er = a[4] ^ b[4];
      sdr = (m_spd_lat < 2'd2);
      odd = 1'b0;
      active = dv || (sdr && (m_nib_idx != 0));
      e_vld = 1'b0; e_rxd = 8'h00; e_dv = 1'b0; e_er = 1'b0;
      if (!sdr) begin
         e_vld = 1'b1; e_rxd = {b[3:0], a[3:0]}; e_dv = dv; e_er = er;
      end else if (dv) begin
         if (m_nib_idx % 2 == 1) begin
            e_vld = 1'b1; e_rxd = {a[3:0], m_low}; e_dv = 1'b1; e_er = m_low_er | er;
         end else begin
            m_low = a[3:0]; m_low_er = er;
         end
      end else if (m_nib_idx % 2 == 1) begin
         e_vld = 1'b1; e_rxd = {4'h0, m_low}; e_dv = 1'b1; e_er = 1'b1; odd = 1'b1;
      end
      m_nib_idx = (sdr && dv) ? m_nib_idx + 1 : 0;
      if (m_prev_dv && !dv) begin
         m_fcnt = m_fcnt + 16'd1;
         if (m_frame_bad || odd) m_ecnt = m_ecnt + 16'd1;
         m_frame_bad = 1'b0;
      end else if (dv && er) begin
         m_frame_bad = 1'b1;
      end
      m_prev_dv = dv;
      if (!active) m_spd_lat = s;
`ifdef RGMII_RX_INBAND_STATUS_EN
      if (!dv && !er) begin
         if (m_st_have && (m_st_prev == a[3:0])) begin
            m_lu = a[0]; m_ls = a[2:1]; m_ld = a[3];
         end
         m_st_prev = a[3:0]; m_st_have = 1'b1;
      end else begin
         m_st_have = 1'b0;
      end
`endif
   endfunction

   task automatic check_model(input string name);
      logic [46:0] act, exp;
      act = {o_rxd, o_dv, o_er, o_vld, o_fc, o_ec, o_lu, o_ls, o_ld};
      exp = {e_rxd, e_dv, e_er, e_vld, m_fcnt, m_ecnt, m_lu, m_ls, m_ld};
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got {rxd,dv,er,vld,fcnt,ecnt,link}=%h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input logic [4:0] a, input logic [4:0] b, input logic [1:0] s, input string name);
      q1 = a; q2 = b; spd = s;
      model_step(a, b, s);
      @(posedge clk); #1;
      check_model(name);
   endtask

   task automatic byte1000(input logic [7:0] bt, input logic [1:0] s, input string name);
      cyc({1'b1, bt[3:0]}, {1'b1, bt[7:4]}, s, name);
   endtask

   task automatic nib(input logic [3:0] n, input logic [1:0] s, input string name);
      cyc({1'b1, n}, {1'b1, n}, s, name);
   endtask

   task automatic idle(input int n, input logic [1:0] s, input string name);
      for (int i = 0; i < n; i++) cyc(5'h00, 5'h00, s, name);
   endtask

   typedef struct {
      logic [4:0]  q1, q2;
      logic [1:0]  spd;
      logic [7:0]  rxd;
      logic        dv, er, vld;
      logic [15:0] fc, ec;
   } vec_t;

   vec_t tbl[17];

   initial begin
      logic [7:0]  bt;
      logic [1:0]  rs;
      logic [3:0]  st;
      logic [4:0]  ra, rb;
      logic [24:0] act, exp;
      int          gap, len;

      // {q1, q2, speed} -> outputs after that edge {rxd, dv, er, valid, frame_cnt, err_cnt}
      tbl[0]  = '{5'h05, 5'h05, 2'd0, 8'h55, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0};
      tbl[1]  = '{5'h05, 5'h05, 2'd2, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
      tbl[2]  = '{5'h15, 5'h15, 2'd2, 8'h55, 1'b1, 1'b0, 1'b1, 16'd0, 16'd0};
      tbl[3]  = '{5'h15, 5'h1D, 2'd2, 8'hD5, 1'b1, 1'b0, 1'b1, 16'd0, 16'd0};
      tbl[4]  = '{5'h11, 5'h10, 2'd2, 8'h01, 1'b1, 1'b0, 1'b1, 16'd0, 16'd0};
      tbl[5]  = '{5'h12, 5'h00, 2'd2, 8'h02, 1'b1, 1'b1, 1'b1, 16'd0, 16'd0};
      tbl[6]  = '{5'h00, 5'h00, 2'd2, 8'h00, 1'b0, 1'b0, 1'b1, 16'd1, 16'd1};
      tbl[7]  = '{5'h03, 5'h12, 2'd2, 8'h23, 1'b0, 1'b1, 1'b1, 16'd1, 16'd1};
      tbl[8]  = '{5'h00, 5'h00, 2'd1, 8'h00, 1'b0, 1'b0, 1'b1, 16'd1, 16'd1};
      tbl[9]  = '{5'h1A, 5'h10, 2'd1, 8'h00, 1'b0, 1'b0, 1'b0, 16'd1, 16'd1};
      tbl[10] = '{5'h1B, 5'h10, 2'd1, 8'hBA, 1'b1, 1'b0, 1'b1, 16'd1, 16'd1};
      tbl[11] = '{5'h00, 5'h00, 2'd1, 8'h00, 1'b0, 1'b0, 1'b0, 16'd2, 16'd1};
      tbl[12] = '{5'h17, 5'h10, 2'd1, 8'h00, 1'b0, 1'b0, 1'b0, 16'd2, 16'd1};
      tbl[13] = '{5'h00, 5'h00, 2'd1, 8'h07, 1'b1, 1'b1, 1'b1, 16'd3, 16'd2};
      tbl[14] = '{5'h00, 5'h00, 2'd2, 8'h00, 1'b0, 1'b0, 1'b0, 16'd3, 16'd2};
      tbl[15] = '{5'h1F, 5'h1E, 2'd2, 8'hEF, 1'b1, 1'b0, 1'b1, 16'd3, 16'd2};
      tbl[16] = '{5'h00, 5'h00, 2'd2, 8'h00, 1'b0, 1'b0, 1'b1, 16'd4, 16'd2};

      // reset state
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_model("reset_state");
      rst_n = 1'b1;

      // directed table
      for (int i = 0; i < 17; i++) begin
         q1 = tbl[i].q1; q2 = tbl[i].q2; spd = tbl[i].spd;
         model_step(tbl[i].q1, tbl[i].q2, tbl[i].spd);
         @(posedge clk); #1;
         act = {o_rxd, o_dv, o_er, o_vld, o_fc[6:0], o_ec[6:0]};
         exp = {tbl[i].rxd, tbl[i].dv, tbl[i].er, tbl[i].vld, tbl[i].fc[6:0], tbl[i].ec[6:0]};
         vectors++;
         if (act !== exp || o_fc !== tbl[i].fc || o_ec !== tbl[i].ec) begin
            miscompares++;
            $display("FAIL table[%0d]: got rxd=%h dv=%b er=%b vld=%b fc=%0d ec=%0d expected rxd=%h dv=%b er=%b vld=%b fc=%0d ec=%0d",
                     i, o_rxd, o_dv, o_er, o_vld, o_fc, o_ec,
                     tbl[i].rxd, tbl[i].dv, tbl[i].er, tbl[i].vld, tbl[i].fc, tbl[i].ec);
         end
      end

      // 1000M frame: preamble, SFD, counting payload
      idle(2, 2'd2, "g1_idle");
      for (int i = 0; i < 7; i++) byte1000(8'h55, 2'd2, "g1_pre");
      byte1000(8'hD5, 2'd2, "g1_sfd");
      for (int i = 1; i <= 8'h3C; i++) begin
         bt = 8'(i);
         byte1000(bt, 2'd2, "g1_data");
      end
      idle(2, 2'd2, "g1_end");

      // 100M nibble pairing
      idle(2, 2'd1, "m100_idle");
      for (int i = 0; i < 15; i++) nib(4'h5, 2'd1, "m100_pre");
      nib(4'hD, 2'd1, "m100_sfd");
      nib(4'hA, 2'd1, "m100_lo");
      nib(4'hB, 2'd1, "m100_hi");
      idle(2, 2'd1, "m100_end");

      // 10M odd nibble count
      idle(2, 2'd0, "m10_idle");
      for (int i = 1; i <= 7; i++) nib(4'(i), 2'd0, "m10_odd");
      idle(2, 2'd0, "m10_end");

      // 1000M receive error on byte 10
      idle(2, 2'd2, "er_idle");
      for (int i = 0; i < 16; i++) begin
         ra = {1'b1, 4'(i)};
         rb = {(i != 10), 4'h3};
         cyc(ra, rb, 2'd2, "er_byte");
      end
      idle(2, 2'd2, "er_end");

      // speed change mid-frame takes effect on the next frame only
      for (int i = 0; i < 8; i++) begin
         bt = 8'(8'h10 + i);
         byte1000(bt, (i < 3) ? 2'd2 : 2'd1, "spd_mid");
      end
      idle(2, 2'd1, "spd_gap");
      for (int i = 0; i < 6; i++) nib(4'(i + 3), 2'd1, "spd_next");
      idle(2, 2'd1, "spd_end");

      // in-band status: rxd=D idle on two consecutive cycles
      cyc(5'h0D, 5'h0D, 2'd1, "status_1");
      cyc(5'h0D, 5'h0D, 2'd1, "status_2");
      vectors++;
      if (o_lu !== EXP_LU || o_ls !== EXP_LS || o_ld !== EXP_LD) begin
         miscompares++;
         $display("FAIL status_fields: got up=%b speed=%0d duplex=%b expected up=%b speed=%0d duplex=%b",
                  o_lu, o_ls, o_ld, EXP_LU, EXP_LS, EXP_LD);
      end

      // random traffic with idle status nibbles, errors and speed flips
      for (int f = 0; f < 60; f++) begin
         rs  = 2'($urandom_range(0, 3));
         gap = $urandom_range(1, 4);
         st  = ($urandom_range(0, 1) == 1) ? 4'hD : 4'($urandom);
         for (int g = 0; g < gap; g++) begin
            ra = {1'b0, st};
            rb = {($urandom_range(0, 9) == 0), st};
            cyc(ra, rb, rs, "rand_idle");
         end
         len = $urandom_range(1, 12);
         for (int k = 0; k < len; k++) begin
            if ($urandom_range(0, 7) == 0) rs = 2'($urandom_range(0, 3));
            ra = {1'b1, 4'($urandom)};
            rb = {($urandom_range(0, 19) != 0), 4'($urandom)};
            cyc(ra, rb, rs, "rand_frame");
         end
      end
      idle(3, 2'd2, "rand_end");

      // asynchronous reset in the middle of a frame
      for (int i = 0; i < 4; i++) byte1000(8'hA0 + 8'(i), 2'd2, "rst_frame");
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({o_rxd, o_dv, o_er, o_vld, o_fc, o_ec, o_lu, o_ls, o_ld} !== 47'h0) begin
         miscompares++;
         $display("FAIL async_reset: got {rxd,dv,er,vld,fcnt,ecnt,link}=%h expected 0",
                  {o_rxd, o_dv, o_er, o_vld, o_fc, o_ec, o_lu, o_ls, o_ld});
      end
      q1 = 5'h00; q2 = 5'h00;
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(3, 2'd2, "post_reset");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
